// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the request side drives the operands,
// and the adder drives status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry, LSB first.
// Results are registered and held until the next operation completes.
//
// state | meaning
// IDLE  | waiting for start; operands and mode are captured on start
// RUN   | one bit per clock through the slice, WIDTH clocks
// DONE  | done pulse for one cycle, then back to IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             busy_r;
  logic             done_r;
  logic             carry_r;
  logic             ovf_r;
  logic             s;
  logic             c_nxt;

  assign s     = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      sum_r   <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_sr   <= bus.a;
            b_sr   <= bus.sub ? ~bus.b : bus.b;
            c      <= bus.sub;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sr <= {s, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c      <= c_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // c here is the carry into the MSB slice; overflow is carry-in xor carry-out.
            sum_r   <= {s, res_sr[WIDTH-1:1]};
            carry_r <= c_nxt;
            ovf_r   <= c_nxt ^ c;
            done_r  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_r;
  assign bus.overflow  = ovf_r;
endmodule
